// File: rtl/vec_engine_pkg.sv
// Shared types and constants for the vector engine: FSM states, lane operations
// and memory request opcodes.
package vec_engine_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReqA,
        StRdA,
        StReqB,
        StRdB,
        StReqC,
        StWrC,
        StDone
    } state_e;

    typedef enum logic [2:0] {
        OpAdd,
        OpSub,
        OpAddSat,
        OpMax,
        OpMin,
        OpAnd,
        OpOr,
        OpXor
    } op_e;

    localparam logic MemOpRead  = 1'b0;
    localparam logic MemOpWrite = 1'b1;

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational SIMD lane ALU: applies one unsigned operation independently to every
// LANE_BITS-wide lane, with no carry or borrow crossing lane boundaries.
module vec_lane_alu #(
    parameter int unsigned LANES     = 8,
    parameter int unsigned LANE_BITS = 8
) (
    input  logic [2:0]                 op,
    input  logic [LANES*LANE_BITS-1:0] a,
    input  logic [LANES*LANE_BITS-1:0] b,
    output logic [LANES*LANE_BITS-1:0] res
);
    import vec_engine_pkg::*;

    logic [LANE_BITS-1:0] la;
    logic [LANE_BITS-1:0] lb;
    logic [LANE_BITS-1:0] lr;
    logic [LANE_BITS:0]   sum;

    always_comb begin
        res = '0;
        la  = '0;
        lb  = '0;
        lr  = '0;
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            la  = a[i*LANE_BITS +: LANE_BITS];
            lb  = b[i*LANE_BITS +: LANE_BITS];
            sum = {1'b0, la} + {1'b0, lb};
            case (op_e'(op))
                OpAdd:    lr = sum[LANE_BITS-1:0];
                OpSub:    lr = la - lb;
                OpAddSat: lr = sum[LANE_BITS] ? '1 : sum[LANE_BITS-1:0];
                OpMax:    lr = (la > lb) ? la : lb;
                OpMin:    lr = (la < lb) ? la : lb;
                OpAnd:    lr = la & lb;
                OpOr:     lr = la | lb;
                OpXor:    lr = la ^ lb;
            endcase
            res[i*LANE_BITS +: LANE_BITS] = lr;
        end
    end

endmodule

// File: rtl/vec_engine.sv
// Vector engine: streams length words from A and B, applies a lane operation, writes C,
// one single-beat request at a time, and reports the launch-to-finish cycle count.
module vec_engine #(
    parameter int unsigned MEM_LEN_BITS   = 8,
    parameter int unsigned MEM_ADDR_BITS  = 32,
    parameter int unsigned MEM_DATA_BITS  = 64,
    parameter int unsigned HOST_DATA_BITS = 32,
    parameter int unsigned LANE_BITS      = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      launch,
    input  logic [2:0]                op,
    input  logic [HOST_DATA_BITS-1:0] length,
    input  logic [HOST_DATA_BITS-1:0] a_addr,
    input  logic [HOST_DATA_BITS-1:0] b_addr,
    input  logic [HOST_DATA_BITS-1:0] c_addr,
    output logic                      finish,
    output logic                      event_counter_valid,
    output logic [HOST_DATA_BITS-1:0] event_counter_value,
    output logic                      mem_req_valid,
    output logic                      mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]   mem_req_len,
    output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
    output logic                      mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
    input  logic                      mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
    output logic                      mem_rd_ready
);
    import vec_engine_pkg::*;

    localparam int unsigned LANES = MEM_DATA_BITS / LANE_BITS;
    localparam logic [HOST_DATA_BITS-1:0] STEP = HOST_DATA_BITS'(MEM_DATA_BITS / 8);
    localparam logic [HOST_DATA_BITS-1:0] ONE  = HOST_DATA_BITS'(1);

    state_e                    state_q;
    logic [2:0]                op_q;
    logic [HOST_DATA_BITS-1:0] a_ptr_q;
    logic [HOST_DATA_BITS-1:0] b_ptr_q;
    logic [HOST_DATA_BITS-1:0] c_ptr_q;
    logic [HOST_DATA_BITS-1:0] remaining_q;
    logic [MEM_DATA_BITS-1:0]  a_q;
    logic [MEM_DATA_BITS-1:0]  b_q;
    logic [MEM_DATA_BITS-1:0]  alu_res;
    logic [HOST_DATA_BITS-1:0] cnt_inc;

    assign mem_req_len = '0;
    assign cnt_inc     = (&event_counter_value) ? event_counter_value : event_counter_value + ONE;

    vec_lane_alu #(
        .LANES    (LANES),
        .LANE_BITS(LANE_BITS)
    ) u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .res(alu_res)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q             <= StIdle;
            op_q                <= '0;
            a_ptr_q             <= '0;
            b_ptr_q             <= '0;
            c_ptr_q             <= '0;
            remaining_q         <= '0;
            a_q                 <= '0;
            b_q                 <= '0;
            finish              <= 1'b0;
            event_counter_valid <= 1'b0;
            event_counter_value <= '0;
            mem_req_valid       <= 1'b0;
            mem_req_opcode      <= 1'b0;
            mem_req_addr        <= '0;
            mem_wr_valid        <= 1'b0;
            mem_wr_bits         <= '0;
            mem_rd_ready        <= 1'b0;
        end else begin
            mem_req_valid       <= 1'b0;
            mem_wr_valid        <= 1'b0;
            finish              <= 1'b0;
            event_counter_valid <= 1'b0;
            if (state_q != StIdle && state_q != StDone) begin
                event_counter_value <= cnt_inc;
            end
            case (state_q)
                StIdle: begin
                    if (launch) begin
                        op_q        <= op;
                        a_ptr_q     <= a_addr;
                        b_ptr_q     <= b_addr;
                        c_ptr_q     <= c_addr;
                        remaining_q <= length;
                        // Counter holds the number of the cycle being entered, so the value
                        // shown alongside finish already includes the DONE cycle.
                        event_counter_value <= ONE;
                        if (length == '0) begin
                            state_q             <= StDone;
                            finish              <= 1'b1;
                            event_counter_valid <= 1'b1;
                        end else begin
                            state_q        <= StReqA;
                            mem_req_valid  <= 1'b1;
                            mem_req_opcode <= MemOpRead;
                            mem_req_addr   <= MEM_ADDR_BITS'(a_addr);
                        end
                    end
                end
                StReqA: begin
                    state_q      <= StRdA;
                    mem_rd_ready <= 1'b1;
                end
                StRdA: begin
                    if (mem_rd_valid && mem_rd_ready) begin
                        a_q            <= mem_rd_bits;
                        mem_rd_ready   <= 1'b0;
                        state_q        <= StReqB;
                        mem_req_valid  <= 1'b1;
                        mem_req_opcode <= MemOpRead;
                        mem_req_addr   <= MEM_ADDR_BITS'(b_ptr_q);
                    end
                end
                StReqB: begin
                    state_q      <= StRdB;
                    mem_rd_ready <= 1'b1;
                end
                StRdB: begin
                    if (mem_rd_valid && mem_rd_ready) begin
                        b_q            <= mem_rd_bits;
                        mem_rd_ready   <= 1'b0;
                        state_q        <= StReqC;
                        mem_req_valid  <= 1'b1;
                        mem_req_opcode <= MemOpWrite;
                        mem_req_addr   <= MEM_ADDR_BITS'(c_ptr_q);
                    end
                end
                StReqC: begin
                    state_q      <= StWrC;
                    mem_wr_valid <= 1'b1;
                    mem_wr_bits  <= alu_res;
                end
                StWrC: begin
                    a_ptr_q     <= a_ptr_q + STEP;
                    b_ptr_q     <= b_ptr_q + STEP;
                    c_ptr_q     <= c_ptr_q + STEP;
                    remaining_q <= remaining_q - ONE;
                    if (remaining_q == ONE) begin
                        state_q             <= StDone;
                        finish              <= 1'b1;
                        event_counter_valid <= 1'b1;
                    end else begin
                        state_q        <= StReqA;
                        mem_req_valid  <= 1'b1;
                        mem_req_opcode <= MemOpRead;
                        mem_req_addr   <= MEM_ADDR_BITS'(a_ptr_q + STEP);
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_engine.sv
// Self-checking bench for vec_engine: directed lane vectors, address stepping, zero length,
// read stalls with a spurious valid, busy launch, mid-transfer reset, and random jobs.
module tb_vec_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        launch = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] length = 32'd0;
    logic [31:0] a_addr = 32'd0;
    logic [31:0] b_addr = 32'd0;
    logic [31:0] c_addr = 32'd0;
    logic        finish;
    logic        event_counter_valid;
    logic [31:0] event_counter_value;
    logic        mem_req_valid;
    logic        mem_req_opcode;
    logic [7:0]  mem_req_len;
    logic [31:0] mem_req_addr;
    logic        mem_wr_valid;
    logic [63:0] mem_wr_bits;
    logic        mem_rd_valid = 1'b0;
    logic [63:0] mem_rd_bits = 64'd0;
    logic        mem_rd_ready;

    vec_engine dut (
        .clock              (clock),
        .reset              (reset),
        .launch             (launch),
        .op                 (op),
        .length             (length),
        .a_addr             (a_addr),
        .b_addr             (b_addr),
        .c_addr             (c_addr),
        .finish             (finish),
        .event_counter_valid(event_counter_valid),
        .event_counter_value(event_counter_value),
        .mem_req_valid      (mem_req_valid),
        .mem_req_opcode     (mem_req_opcode),
        .mem_req_len        (mem_req_len),
        .mem_req_addr       (mem_req_addr),
        .mem_wr_valid       (mem_wr_valid),
        .mem_wr_bits        (mem_wr_bits),
        .mem_rd_valid       (mem_rd_valid),
        .mem_rd_bits        (mem_rd_bits),
        .mem_rd_ready       (mem_rd_ready)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Memory contents (written only by the main sequence) and responder logs.
    logic [63:0] mem [logic [31:0]];
    int          run_id = 0;
    int          seen_id = 0;
    int          delay_a = 0;
    int          delay_b = 0;
    bit          spurious = 1'b0;
    logic [31:0] req_addr_q [$];
    logic        req_op_q [$];
    logic [31:0] wr_addr_q [$];
    logic [63:0] wr_data_q [$];
    int          tot_req = 0;
    int          tot_wr = 0;
    int          tot_fin = 0;
    int          proto_err = 0;
    bit          pending = 1'b0;
    int          wait_left = 0;
    int          rd_idx = 0;
    logic [31:0] pend_addr = 32'd0;
    logic [31:0] wr_addr_cur = 32'd0;

    function automatic logic [63:0] mem_read(input logic [31:0] addr);
        if (mem.exists(addr)) return mem[addr];
        return {addr ^ 32'h5A5A_A5A5, ~addr};
    endfunction

    // Lane-by-lane reference built from plain integer arithmetic.
    function automatic logic [63:0] ref_op(input logic [2:0] fop, input logic [63:0] a,
                                           input logic [63:0] b);
        logic [63:0] r;
        int unsigned x, y, z;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            x = a[i*8 +: 8];
            y = b[i*8 +: 8];
            case (fop)
                3'd0:    z = (x + y) % 256;
                3'd1:    z = (x + 256 - y) % 256;
                3'd2:    z = (x + y > 255) ? 255 : x + y;
                3'd3:    z = (x > y) ? x : y;
                3'd4:    z = (x < y) ? x : y;
                3'd5:    z = x & y;
                3'd6:    z = x | y;
                default: z = x ^ y;
            endcase
            r[i*8 +: 8] = z[7:0];
        end
        return r;
    endfunction

    // Memory responder: single-beat reads with per-operand delay, write logging.
    always @(posedge clock) begin
        #1;
        mem_rd_valid = 1'b0;
        if (run_id != seen_id) begin
            seen_id = run_id;
            req_addr_q.delete();
            req_op_q.delete();
            wr_addr_q.delete();
            wr_data_q.delete();
            rd_idx = 0;
        end
        if (reset) begin
            pending = 1'b0;
        end else begin
            if (finish) tot_fin++;
            if (mem_wr_valid) begin
                tot_wr++;
                wr_addr_q.push_back(wr_addr_cur);
                wr_data_q.push_back(mem_wr_bits);
            end
            if (mem_req_valid) begin
                tot_req++;
                if (pending || mem_req_len != 8'd0) proto_err++;
                req_addr_q.push_back(mem_req_addr);
                req_op_q.push_back(mem_req_opcode);
                if (mem_req_opcode == 1'b0) begin
                    pending   = 1'b1;
                    pend_addr = mem_req_addr;
                    wait_left = (rd_idx % 2 == 0) ? delay_a : delay_b;
                    if (spurious && rd_idx % 2 == 1) begin
                        mem_rd_valid = 1'b1;
                        mem_rd_bits  = 64'hDEAD_BEEF_0BAD_F00D;
                    end
                    rd_idx++;
                end else begin
                    wr_addr_cur = mem_req_addr;
                end
            end else if (pending && mem_rd_ready) begin
                if (wait_left == 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_bits  = mem_read(pend_addr);
                    pending      = 1'b0;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input string tag, input logic [2:0] jop, input int len,
                           input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] c0,
                           input int da, input int db, input bit spur, input bit busy_l);
        int          cyc;
        int          exp_cyc;
        int          seq_err;
        logic [31:0] base;
        logic [63:0] exp_c [$];
        exp_cyc = 6 * len + 1 + len * (da + db);
        for (int i = 0; i < len; i++) begin
            exp_c.push_back(ref_op(jop, mem_read(a0 + 32'(8 * i)), mem_read(b0 + 32'(8 * i))));
        end
        delay_a  = da;
        delay_b  = db;
        spurious = spur;
        @(negedge clock);
        run_id++;
        op     = jop;
        length = 32'(len);
        a_addr = a0;
        b_addr = b0;
        c_addr = c0;
        launch = 1'b1;
        @(negedge clock);
        launch = 1'b0;
        cyc = 1;
        while (!finish && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (busy_l && cyc == 3) begin
                launch = 1'b1;
                op     = 3'd7;
                length = 32'd0;
            end else begin
                launch = 1'b0;
            end
        end
        launch = 1'b0;
        check({tag, " cycles"}, 64'(cyc), 64'(exp_cyc));
        check({tag, " counter"}, 64'({event_counter_valid, event_counter_value}),
              64'({1'b1, 32'(exp_cyc)}));
        @(negedge clock);
        check({tag, " pulse"}, 64'({finish, event_counter_valid}), 64'd0);
        check({tag, " nreq"}, 64'(req_addr_q.size()), 64'(3 * len));
        if (req_addr_q.size() == 3 * len) begin
            seq_err = 0;
            for (int i = 0; i < len; i++) begin
                for (int k = 0; k < 3; k++) begin
                    base = (k == 0) ? a0 : ((k == 1) ? b0 : c0);
                    if (req_addr_q[3*i+k] !== base + 32'(8 * i) || req_op_q[3*i+k] !== (k == 2))
                        seq_err++;
                end
            end
            check({tag, " reqseq"}, 64'(seq_err), 64'd0);
        end
        check({tag, " nwr"}, 64'(wr_data_q.size()), 64'(len));
        for (int i = 0; i < len && i < wr_data_q.size(); i++) begin
            check($sformatf("%s wraddr%0d", tag, i), 64'(wr_addr_q[i]), 64'(c0 + 32'(8 * i)));
            check($sformatf("%s wrdata%0d", tag, i), wr_data_q[i], exp_c[i]);
        end
        check({tag, " proto"}, 64'(proto_err), 64'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
    } vec_t;

    vec_t        tbl [8];
    logic [2:0]  rop;
    int          rlen;
    logic [31:0] ra, rb, rc;
    int          snap;

    initial begin
        tbl[0] = '{3'd0, 64'h01FF_01FF_01FF_01FF, 64'h0101_0101_0101_0101, 64'h0200_0200_0200_0200};
        tbl[1] = '{3'd1, 64'h0000_0000_0000_0000, 64'h0101_0101_0101_0101, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[2] = '{3'd2, 64'h10F0_F0F0_F0F0_F0F0, 64'h2020_2020_2020_2020, 64'h30FF_FFFF_FFFF_FFFF};
        tbl[3] = '{3'd3, 64'h7F80_7F80_7F80_7F80, 64'h807F_807F_807F_807F, 64'h8080_8080_8080_8080};
        tbl[4] = '{3'd4, 64'h7F80_7F80_7F80_7F80, 64'h807F_807F_807F_807F, 64'h7F7F_7F7F_7F7F_7F7F};
        tbl[5] = '{3'd5, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000};
        tbl[6] = '{3'd6, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFFF0_FFF0_FFF0_FFF0};
        tbl[7] = '{3'd7, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0};

        repeat (3) @(negedge clock);
        check("reset outputs", 64'({finish, event_counter_valid, event_counter_value, mem_req_valid,
              mem_req_opcode, mem_req_len, mem_wr_valid, mem_rd_ready, |mem_req_addr,
              |mem_wr_bits}), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle after reset", 64'({finish, mem_req_valid, mem_wr_valid, mem_rd_ready}), 64'd0);

        for (int i = 0; i < 8; i++) begin
            mem[32'h100] = tbl[i].a;
            mem[32'h200] = tbl[i].b;
            run_job($sformatf("tbl%0d", i), tbl[i].op, 1, 32'h100, 32'h200, 32'h300, 0, 0, 1'b0,
                    1'b0);
            if (wr_data_q.size() > 0) check($sformatf("tbl%0d result", i), wr_data_q[0], tbl[i].c);
        end

        for (int i = 0; i < 4; i++) begin
            mem[32'h1000 + 32'(8 * i)] = {$urandom, $urandom};
            mem[32'h2000 + 32'(8 * i)] = {$urandom, $urandom};
        end
        run_job("len4", 3'd0, 4, 32'h1000, 32'h2000, 32'h3000, 0, 0, 1'b0, 1'b0);
        if (wr_addr_q.size() == 4) check("len4 last wr", 64'(wr_addr_q[3]), 64'h3018);

        snap = tot_req;
        run_job("len0", 3'd0, 0, 32'h1000, 32'h2000, 32'h3000, 0, 0, 1'b0, 1'b0);
        check("len0 no req", 64'(tot_req - snap), 64'd0);

        run_job("stall", 3'd2, 1, 32'h1000, 32'h2000, 32'h3000, 0, 5, 1'b1, 1'b0);
        run_job("busy", 3'd1, 2, 32'h1000, 32'h2000, 32'h3000, 0, 0, 1'b0, 1'b1);

        // Reset while waiting in RD_B.
        delay_a  = 0;
        delay_b  = 8;
        spurious = 1'b0;
        @(negedge clock);
        run_id++;
        op     = 3'd0;
        length = 32'd1;
        a_addr = 32'h1000;
        b_addr = 32'h2000;
        c_addr = 32'h3000;
        launch = 1'b1;
        @(negedge clock);
        launch = 1'b0;
        repeat (4) @(negedge clock);
        check("rst in rdb ready", 64'(mem_rd_ready), 64'd1);
        reset = 1'b1;
        #1;
        check("rst outputs", 64'({finish, event_counter_valid, event_counter_value, mem_req_valid,
              mem_req_opcode, mem_req_len, mem_wr_valid, mem_rd_ready, |mem_req_addr,
              |mem_wr_bits}), 64'd0);
        snap = tot_req + tot_wr + tot_fin;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        check("rst quiet", 64'(tot_req + tot_wr + tot_fin - snap), 64'd0);
        run_job("post_rst", 3'd7, 2, 32'h1000, 32'h2000, 32'h3000, 0, 0, 1'b0, 1'b0);

        for (int it = 0; it < 16; it++) begin
            rop  = 3'($urandom_range(0, 7));
            rlen = $urandom_range(1, 4);
            ra   = $urandom & 32'hFFFF_FFF8;
            rb   = $urandom & 32'hFFFF_FFF8;
            rc   = $urandom & 32'hFFFF_FFF8;
            if (it == 0) ra = 32'hFFFF_FFF0;
            for (int i = 0; i < rlen; i++) begin
                mem[ra + 32'(8 * i)] = {$urandom, $urandom};
                mem[rb + 32'(8 * i)] = {$urandom, $urandom};
            end
            run_job($sformatf("rnd%0d", it), rop, rlen, ra, rb, rc, $urandom_range(0, 2),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
